// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad capture path: key codes, debounce
// state encoding, the BCD display word and the operand accumulate helper.
package teclado_pkg;

  localparam logic [3:0] K_NONE  = 4'hF;
  localparam logic [3:0] K_CLEAR = 4'hE;
  localparam logic [3:0] K_ENTER = 4'hA;

  // Debounce FSM states; encoding is stable so it can be probed on the bus.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAND    = 2'd1,
    PRESSED = 2'd2
  } deb_state_t;

  // Three packed BCD digits, most recent digit in [3:0].
  typedef logic [11:0] bcd_t;

  // Codes 0..9 are decimal digits.
  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  // acc*10 + d. Callers only use this with at most two digits already
  // accumulated, so the result never exceeds 999 and fits in 10 bits.
  function automatic logic [9:0] acc_push(input logic [9:0] acc,
                                          input logic [3:0] d);
    logic [13:0] t;
    t = ({4'd0, acc} * 14'd10) + {10'd0, d};
    return t[9:0];
  endfunction

endpackage

// File: rtl/captura_numero_if.sv
// Bus between the scanner/consumer side and captura_numero.
// Event semantics: tecla_valid and num_valid are single-cycle strobes with
// no ready/back-pressure; the payload (tecla, numero) is valid in the strobe
// cycle and holds afterwards until the next strobe. bcd/digitos are live
// state, not qualified by any strobe. estado is a debug view of the
// debounce FSM.
interface captura_numero_if;
  import teclado_pkg::*;

  logic [3:0] boton;
  logic [3:0] tecla;
  logic       tecla_valid;
  bcd_t       bcd;
  logic [1:0] digitos;
  logic [9:0] numero;
  logic       num_valid;
  deb_state_t estado;

  // Side that drives key codes and consumes results.
  modport master (
    output boton,
    input  tecla, tecla_valid, bcd, digitos, numero, num_valid, estado
  );

  // captura_numero itself.
  modport slave (
    input  boton,
    output tecla, tecla_valid, bcd, digitos, numero, num_valid, estado
  );

endinterface

// File: rtl/antirrebote.sv
// Debounce / press-release qualifier. The scanner only reports a held key
// while its column is being scanned, so a press arrives as bursts of the
// code separated by 4'hF. A press is accepted after PRESS_CYC matching
// samples of the same code with no release timeout in between; a release
// is declared after RELEASE_CYC consecutive 4'hF samples.
module antirrebote
  import teclado_pkg::*;
#(
  parameter int PRESS_CYC   = 270000,
  parameter int RELEASE_CYC = 108000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] boton,
  output logic [3:0] tecla,
  output logic       tecla_valid,
  output deb_state_t estado
);

  localparam int PW = (PRESS_CYC > 1) ? $clog2(PRESS_CYC) : 1;
  localparam int RW = $clog2(RELEASE_CYC + 1);

  localparam logic [PW-1:0] PRESS_LAST = PW'(PRESS_CYC - 1);
  localparam logic [RW-1:0] REL_LOAD   = RW'(RELEASE_CYC);
  localparam logic [RW-1:0] REL_ONE    = RW'(1);

  deb_state_t    state, state_n;
  logic [3:0]    cand, cand_n;
  logic [PW-1:0] press_cnt, press_n;
  logic [RW-1:0] rel_cnt, rel_n;
  logic [3:0]    tecla_q, tecla_n;
  logic          tv_q, tv_n;
  logic          hit;

  assign hit = (boton != K_NONE);

  // Next-state logic: candidate tracking, press qualification, release timeout.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    press_n = press_cnt;
    rel_n   = rel_cnt;
    tecla_n = tecla_q;
    tv_n    = 1'b0;

    case (state)
      IDLE: begin
        if (hit) begin
          cand_n  = boton;
          press_n = '0;
          rel_n   = REL_LOAD;
          state_n = CAND;
        end
      end

      CAND: begin
        if (hit) begin
          rel_n = REL_LOAD;
          if (boton != cand) begin
            // A different code restarts qualification on the new key.
            cand_n  = boton;
            press_n = '0;
          end else if (press_cnt == PRESS_LAST) begin
            tv_n    = 1'b1;
            tecla_n = cand;
            press_n = '0;
            state_n = PRESSED;
          end else begin
            press_n = press_cnt + 1'b1;
          end
        end else begin
          // Gaps between column bursts only run the release timer. A press
          // can only complete on a hit sample, so a timeout always wins.
          if (rel_cnt <= REL_ONE) begin
            rel_n   = '0;
            press_n = '0;
            state_n = IDLE;
          end else begin
            rel_n = rel_cnt - 1'b1;
          end
        end
      end

      PRESSED: begin
        // Any code keeps the key held; another key cannot roll over.
        if (hit) begin
          rel_n = REL_LOAD;
        end else if (rel_cnt <= REL_ONE) begin
          rel_n   = '0;
          state_n = IDLE;
        end else begin
          rel_n = rel_cnt - 1'b1;
        end
      end

      default: begin
        state_n = IDLE;
        press_n = '0;
        rel_n   = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cand      <= K_NONE;
      press_cnt <= '0;
      rel_cnt   <= '0;
      tecla_q   <= K_NONE;
      tv_q      <= 1'b0;
    end else begin
      state     <= state_n;
      cand      <= cand_n;
      press_cnt <= press_n;
      rel_cnt   <= rel_n;
      tecla_q   <= tecla_n;
      tv_q      <= tv_n;
    end
  end

  assign tecla       = tecla_q;
  assign tecla_valid = tv_q;
  assign estado      = state;

endmodule

// File: rtl/captura_numero.sv
// Keypad operand capture: debounced key events feed a three-digit decimal
// accumulator. Digits shift into the live BCD display; enter commits the
// binary value to numero with a one-cycle num_valid; '*' clears the entry.
module captura_numero
  import teclado_pkg::*;
#(
  parameter int PRESS_CYC   = 270000,
  parameter int RELEASE_CYC = 108000
) (
  input  logic               clk,
  input  logic               rst,
  captura_numero_if.slave    bus
);

  logic [3:0] tecla;
  logic       tecla_valid;
  deb_state_t estado;

  antirrebote #(
    .PRESS_CYC   (PRESS_CYC),
    .RELEASE_CYC (RELEASE_CYC)
  ) u_antirrebote (
    .clk         (clk),
    .rst         (rst),
    .boton       (bus.boton),
    .tecla       (tecla),
    .tecla_valid (tecla_valid),
    .estado      (estado)
  );

  logic [9:0] acc_q, acc_n;
  bcd_t       bcd_q, bcd_n;
  logic [1:0] dig_q, dig_n;
  logic [9:0] num_q, num_n;
  logic       nv_q, nv_n;

  // Accumulator next-state: act only on an accepted key event.
  always_comb begin
    acc_n = acc_q;
    bcd_n = bcd_q;
    dig_n = dig_q;
    num_n = num_q;
    nv_n  = 1'b0;

    if (tecla_valid) begin
      if (is_digit(tecla)) begin
        // A fourth digit is dropped rather than wrapping the entry.
        if (dig_q != 2'd3) begin
          acc_n = acc_push(acc_q, tecla);
          bcd_n = {bcd_q[7:0], tecla};
          dig_n = dig_q + 2'd1;
        end
      end else if (tecla == K_CLEAR) begin
        // Clear discards the entry but keeps the last committed operand.
        acc_n = '0;
        bcd_n = '0;
        dig_n = '0;
      end else if (tecla == K_ENTER) begin
        // Enter with an empty entry would commit a bogus zero; ignore it.
        if (dig_q != 2'd0) begin
          num_n = acc_q;
          nv_n  = 1'b1;
          acc_n = '0;
          bcd_n = '0;
          dig_n = '0;
        end
      end
      // B, C, D: visible on tecla only.
    end
  end

  // Accumulator and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      bcd_q <= '0;
      dig_q <= '0;
      num_q <= '0;
      nv_q  <= 1'b0;
    end else begin
      acc_q <= acc_n;
      bcd_q <= bcd_n;
      dig_q <= dig_n;
      num_q <= num_n;
      nv_q  <= nv_n;
    end
  end

  assign bus.tecla       = tecla;
  assign bus.tecla_valid = tecla_valid;
  assign bus.estado      = estado;
  assign bus.bcd         = bcd_q;
  assign bus.digitos     = dig_q;
  assign bus.numero      = num_q;
  assign bus.num_valid   = nv_q;

endmodule

// File: tb/tb_captura_numero.sv
// Bench for captura_numero with short debounce constants. Keys are driven
// as scanner-like bursts (5 cycles of code, 15 of 4'hF); a negedge monitor
// counts strobes and snapshots the accumulator one cycle after each event.
module tb_captura_numero;
  import teclado_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  captura_numero_if bus();

  captura_numero #(
    .PRESS_CYC   (8),
    .RELEASE_CYC (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int         tv_count = 0;
  int         nv_count = 0;
  logic       tv_prev  = 1'b0;
  logic [3:0] last_tecla = 4'hF;
  logic [11:0] snap_bcd = '0;
  logic [1:0]  snap_dig = '0;
  logic [9:0]  snap_num = '0;
  logic        snap_nv  = 1'b0;

  typedef struct {
    logic [3:0]  key;
    logic [11:0] bcd;
    logic [1:0]  dig;
    logic [9:0]  num;
    logic        nv;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: count strobes, snapshot state the cycle after each key event.
  always @(negedge clk) begin
    if (tv_prev) begin
      chk("tv_single_cycle", {31'd0, bus.tecla_valid}, 32'd0);
      snap_bcd = bus.bcd;
      snap_dig = bus.digitos;
      snap_num = bus.numero;
      snap_nv  = bus.num_valid;
    end
    if (bus.tecla_valid) begin
      tv_count++;
      last_tecla = bus.tecla;
    end
    if (bus.num_valid) nv_count++;
    tv_prev = bus.tecla_valid;
  end

  // Hold boton at b for n clock edges; called at a negedge.
  task automatic drive(input logic [3:0] b, input int n);
    bus.boton = b;
    repeat (n) @(negedge clk);
  endtask

  // Three scanner bursts of the key, then a long release gap.
  task automatic press_key(input logic [3:0] k);
    repeat (3) begin
      drive(k, 5);
      drive(K_NONE, 15);
    end
    drive(K_NONE, 40);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tecla"},   {28'd0, bus.tecla}, 32'hF);
    chk({tag, "_tv"},      {31'd0, bus.tecla_valid}, 32'd0);
    chk({tag, "_bcd"},     {20'd0, bus.bcd}, 32'd0);
    chk({tag, "_digitos"}, {30'd0, bus.digitos}, 32'd0);
    chk({tag, "_numero"},  {22'd0, bus.numero}, 32'd0);
    chk({tag, "_nv"},      {31'd0, bus.num_valid}, 32'd0);
    chk({tag, "_estado"},  {30'd0, bus.estado}, {30'd0, IDLE});
  endtask

  initial begin
    int tv0;
    int nv0;

    vecs[0]  = '{4'hE, 12'h000, 2'd0, 10'd0,   1'b0};
    vecs[1]  = '{4'h1, 12'h001, 2'd1, 10'd0,   1'b0};
    vecs[2]  = '{4'h2, 12'h012, 2'd2, 10'd0,   1'b0};
    vecs[3]  = '{4'h3, 12'h123, 2'd3, 10'd0,   1'b0};
    vecs[4]  = '{4'hA, 12'h000, 2'd0, 10'd123, 1'b1};
    vecs[5]  = '{4'h9, 12'h009, 2'd1, 10'd123, 1'b0};
    vecs[6]  = '{4'h9, 12'h099, 2'd2, 10'd123, 1'b0};
    vecs[7]  = '{4'h9, 12'h999, 2'd3, 10'd123, 1'b0};
    vecs[8]  = '{4'h4, 12'h999, 2'd3, 10'd123, 1'b0};
    vecs[9]  = '{4'hA, 12'h000, 2'd0, 10'd999, 1'b1};
    vecs[10] = '{4'h7, 12'h007, 2'd1, 10'd999, 1'b0};
    vecs[11] = '{4'hE, 12'h000, 2'd0, 10'd999, 1'b0};
    vecs[12] = '{4'hA, 12'h000, 2'd0, 10'd999, 1'b0};
    vecs[13] = '{4'hB, 12'h000, 2'd0, 10'd999, 1'b0};

    // Reset, then idle
    bus.boton = K_NONE;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("in_reset");
    rst = 1'b0;
    drive(K_NONE, 200);
    chk_reset_outputs("idle200");
    chk("idle_tv_count", tv_count, 0);
    chk("idle_nv_count", nv_count, 0);

    // Steady key 5: event exactly 9 negedges after t0
    bus.boton = 4'h5;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i < 9) begin
        chk($sformatf("steady_early_tv_%0d", i), {31'd0, bus.tecla_valid}, 32'd0);
      end else if (i == 9) begin
        chk("steady_tv_t0p9", {31'd0, bus.tecla_valid}, 32'd1);
        chk("steady_tecla",   {28'd0, bus.tecla}, 32'h5);
      end else begin
        chk("steady_tv_drop", {31'd0, bus.tecla_valid}, 32'd0);
        chk("steady_bcd",     {20'd0, bus.bcd}, 32'h005);
        chk("steady_digitos", {30'd0, bus.digitos}, 32'd1);
      end
    end
    drive(4'h5, 290);
    chk("steady_hold_one_event", tv_count, 1);
    chk("steady_estado_pressed", {30'd0, bus.estado}, {30'd0, PRESSED});
    drive(K_NONE, 40);
    chk("steady_released", {30'd0, bus.estado}, {30'd0, IDLE});
    chk("steady_tecla_holds", {28'd0, bus.tecla}, 32'h5);

    // Table of burst-driven keys
    for (int i = 0; i < 14; i++) begin
      tv0 = tv_count;
      nv0 = nv_count;
      press_key(vecs[i].key);
      chk($sformatf("v%0d_one_event", i), tv_count - tv0, 1);
      chk($sformatf("v%0d_tecla", i),     {28'd0, last_tecla}, {28'd0, vecs[i].key});
      chk($sformatf("v%0d_bcd", i),       {20'd0, snap_bcd}, {20'd0, vecs[i].bcd});
      chk($sformatf("v%0d_digitos", i),   {30'd0, snap_dig}, {30'd0, vecs[i].dig});
      chk($sformatf("v%0d_numero", i),    {22'd0, snap_num}, {22'd0, vecs[i].num});
      chk($sformatf("v%0d_num_valid", i), {31'd0, snap_nv}, {31'd0, vecs[i].nv});
      chk($sformatf("v%0d_nv_count", i),  nv_count - nv0, {31'd0, vecs[i].nv});
      chk($sformatf("v%0d_numero_hold", i), {22'd0, bus.numero}, {22'd0, vecs[i].num});
    end

    // Glitch shorter than the press time, then release timeout
    tv0 = tv_count;
    drive(4'h3, 4);
    chk("glitch_cand", {30'd0, bus.estado}, {30'd0, CAND});
    drive(K_NONE, 25);
    chk("glitch_no_event", tv_count - tv0, 0);
    chk("glitch_idle", {30'd0, bus.estado}, {30'd0, IDLE});

    // Reset mid-candidate with two digits entered
    press_key(4'h1);
    press_key(4'h2);
    chk("pre_rst_digitos", {30'd0, bus.digitos}, 32'd2);
    chk("pre_rst_bcd", {20'd0, bus.bcd}, 32'h012);
    drive(4'h4, 3);
    chk("pre_rst_cand", {30'd0, bus.estado}, {30'd0, CAND});
    tv0 = tv_count;
    rst = 1'b1;
    bus.boton = K_NONE;
    @(negedge clk);
    chk_reset_outputs("mid_rst");
    rst = 1'b0;
    drive(K_NONE, 60);
    chk("post_rst_no_event", tv_count - tv0, 0);
    chk_reset_outputs("post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
